// File: rtl/multiport_memory.sv
// One-write / two-read register-file memory with write-first bypass and a
// sequential clear engine that reloads every word with INIT_VAL.
module multiport_memory #(
    parameter int                 DATA_W   = 8,
    parameter int                 DEPTH    = 4,
    parameter int                 ADDR_W   = $clog2(DEPTH),
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] data_input,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    input  logic              clr,
    output logic [DATA_W-1:0] data_output_a,
    output logic [DATA_W-1:0] data_output_b,
    output logic              busy,
    output logic              wr_drop
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
    logic              busy_q, busy_d;
    logic              wr_drop_q, wr_drop_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              waddr_ok;

    // Zero-extend before comparing so non-power-of-two depths work without
    // the compare collapsing to a constant.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < DEPTH_X;
    endfunction

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        if (state_q == CLEAR)
            return INIT_VAL;
        else if (!in_range(addr))
            return '0;
        else if (we && addr == waddr)
            return data_input;
        else
            return mem_q[addr];
    endfunction

    assign waddr_ok = in_range(waddr);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        wr_drop_d = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = waddr;
        mem_wdata = data_input;
        rdata_a_d = read_port(raddr_a);
        rdata_b_d = read_port(raddr_b);

        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = ptr_q;
            mem_wdata = INIT_VAL;
            wr_drop_d = we;
            ptr_d     = ptr_q + 1'b1;
            if (ptr_q == LAST_ADDR) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ptr_d   = '0;
            end
        end else begin
            // A write coinciding with clr still lands; the clear pass then overwrites it.
            mem_we    = we && waddr_ok;
            wr_drop_d = we && !waddr_ok;
            if (clr) begin
                state_d = CLEAR;
                ptr_d   = '0;
                busy_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            ptr_q     <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            busy_q    <= 1'b1;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            busy_q    <= busy_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst)
            mem_q[mem_addr] <= mem_wdata;
    end

    assign data_output_a = rdata_a_q;
    assign data_output_b = rdata_b_q;
    assign busy          = busy_q;
    assign wr_drop       = wr_drop_q;

endmodule

// File: doc/multiport_memory.md
MULTIPORT_MEMORY -- requirements
Module: multiport_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of words (>=2, power of two not required).
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), address width.
REQ-004 SHALL have parameter INIT_VAL, default 0, DATA_W-bit value loaded by the clear sequence.
REQ-005 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port: we  input  1  write enable.
REQ-008 SHALL have port: waddr  input  ADDR_W  write address.
REQ-009 SHALL have port: data_input  input  DATA_W  write data.
REQ-010 SHALL have port: raddr_a  input  ADDR_W  read port A address.
REQ-011 SHALL have port: raddr_b  input  ADDR_W  read port B address.
REQ-012 SHALL have port: clr  input  1  request to reload every word with INIT_VAL.
REQ-013 SHALL have port: data_output_a  output  DATA_W  registered read data, port A.
REQ-014 SHALL have port: data_output_b  output  DATA_W  registered read data, port B.
REQ-015 SHALL have port: busy  output  1  high while the clear sequence runs.
REQ-016 SHALL have port: wr_drop  output  1  one-cycle pulse when a write is discarded.

Function
REQ-017 SHALL implement an FSM with states IDLE and CLEAR plus an ADDR_W-bit clear pointer.
REQ-018 In IDLE, SHALL write data_input to word waddr at the edge where we=1 and waddr<DEPTH.
REQ-019 SHALL give each read port 1-cycle latency: output after edge N reflects the raddr sampled at edge N.
REQ-020 SHALL bypass writes: if we=1 in IDLE and raddr_x==waddr at edge N, data_output_x after edge N equals data_input (write-first).
REQ-021 SHALL return 0 on a read port whose sampled raddr >= DEPTH.
REQ-022 SHALL ignore writes with waddr >= DEPTH, pulsing wr_drop=1 for that cycle.
REQ-023 IDLE->CLEAR at an edge with clr=1; pointer loads 0; busy=1 from the next cycle.
REQ-024 In CLEAR, SHALL write INIT_VAL to word[pointer] each cycle and increment the pointer.
REQ-025 CLEAR->IDLE at the edge writing word DEPTH-1; busy=0 from the next cycle; CLEAR lasts exactly DEPTH cycles.
REQ-026 In CLEAR, SHALL ignore clr (no restart) and discard we=1 with wr_drop=1 for that cycle.
REQ-027 In CLEAR, both read ports SHALL output INIT_VAL, regardless of address.
REQ-028 If we=1 and clr=1 at the same IDLE edge, SHALL perform the write, then enter CLEAR, which overwrites it.
REQ-029 SHALL allow raddr_a==raddr_b; both ports then return identical data.
REQ-030 wr_drop SHALL be registered and high only in the cycle after the offending edge.

Reset
REQ-031 rst=1 at an edge SHALL force state CLEAR, pointer 0, data_output_a/b=0, wr_drop=0, busy=1, overriding all other inputs.
REQ-032 After rst deasserts, the clear sequence SHALL run DEPTH cycles, so contents are INIT_VAL before the first accepted write.
REQ-033 rst asserted mid-CLEAR SHALL restart the sequence from pointer 0.

Verification
REQ-034 Defaults; rst 2 cycles, release, wait busy=0 -> busy high exactly 4 cycles; reads of 0..3 return 0.
REQ-035 Write 10,32,64 to 0,1,2; read A=0,B=1, then A=2,B=3 -> 10/32 after 1 cycle, then 64/0.
REQ-036 we=1 waddr=1 data 0x55 with raddr_a=1 same edge -> data_output_a=0x55 the next cycle.
REQ-037 INIT_VAL=0xA5; fill all words, pulse clr, assert we during busy -> wr_drop pulses, reads give 0xA5 throughout and after.
REQ-038 DEPTH=5, DATA_W=16: write 0x1234 to addr 7 -> wr_drop=1, no word changed; read addr 6 -> 0.
REQ-039 Assert rst on the 2nd CLEAR cycle -> outputs 0 and busy then stays high DEPTH cycles after rst release.
